// File: rtl/rs_issue_arbiter_pkg.sv
// Shared definitions for the reservation-station issue arbiter: default sizing,
// index-width helper, issue slot packet and a lowest-set-bit helper.
package rs_issue_arbiter_pkg;

    localparam int DEF_Q_SIZE      = 32;
    localparam int DEF_ISSUE_WIDTH = 3;
    localparam int DEF_NUM_MULT    = 2;
    localparam int DEF_MULT_LAT    = 4;

    function automatic int cal_idx_len(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_INDEX_LEN = cal_idx_len(DEF_Q_SIZE);
    localparam int DEF_UNIT_LEN  = cal_idx_len(DEF_NUM_MULT);

    typedef struct packed {
        logic [DEF_INDEX_LEN-1:0] idx;
        logic                     valid;
        logic                     mult;
        logic [DEF_UNIT_LEN-1:0]  unit;
    } issue_slot_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int lowest_set(input logic [31:0] vec);
        int r;
        r = 0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                r = i;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_issue_arbiter_mult_unit_tracker.sv
// Busy-counter bank for the non-pipelined multiplier units. A unit is free
// when its counter is zero; a grant loads MULT_LAT-1 and the counter drains.
module mult_unit_tracker
    import rs_issue_arbiter_pkg::*;
#(
    parameter int NUM_MULT = DEF_NUM_MULT,
    parameter int MULT_LAT = DEF_MULT_LAT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic [NUM_MULT-1:0] load,
    output logic [NUM_MULT-1:0] mult_free
);

    localparam int CNT_LEN = cal_idx_len(MULT_LAT);
    localparam logic [CNT_LEN-1:0] LOAD_VAL = CNT_LEN'(MULT_LAT - 1);

    logic [CNT_LEN-1:0] busy_cnt_r [NUM_MULT];

    // Per-unit busy counter: clear, load on grant to a free unit, else drain.
    always_ff @(posedge clock) begin
        for (int u = 0; u < NUM_MULT; u++) begin
            if (reset || clear) begin
                busy_cnt_r[u] <= '0;
            end else if (load[u] && (busy_cnt_r[u] == '0)) begin
                busy_cnt_r[u] <= LOAD_VAL;
            end else if (busy_cnt_r[u] != '0) begin
                busy_cnt_r[u] <= busy_cnt_r[u] - CNT_LEN'(1);
            end else begin
                busy_cnt_r[u] <= busy_cnt_r[u];
            end
        end
    end

    // Free flags; forced high during reset so the reset cycle reports all units free.
    always_comb begin
        for (int u = 0; u < NUM_MULT; u++) begin
            if (reset) begin
                mult_free[u] = 1'b1;
            end else begin
                mult_free[u] = (busy_cnt_r[u] == '0);
            end
        end
    end

endmodule

// File: rtl/rs_issue_arbiter.sv
// Reservation-station issue arbiter: rotating-priority scan over ready entries,
// packs up to ISSUE_WIDTH grants per cycle and assigns free multiplier units.
module rs_issue_arbiter
    import rs_issue_arbiter_pkg::*;
#(
    parameter int Q_SIZE      = DEF_Q_SIZE,
    parameter int ISSUE_WIDTH = DEF_ISSUE_WIDTH,
    parameter int NUM_MULT    = DEF_NUM_MULT,
    parameter int MULT_LAT    = DEF_MULT_LAT,
    localparam int INDEX_LEN  = cal_idx_len(Q_SIZE),
    localparam int UNIT_LEN   = cal_idx_len(NUM_MULT)
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [Q_SIZE-1:0]                    request,
    input  logic [Q_SIZE-1:0]                    req_mult,
    input  logic                                 stall,
    input  logic                                 squash,
    output logic [ISSUE_WIDTH-1:0][INDEX_LEN-1:0] issue_idx,
    output logic [ISSUE_WIDTH-1:0]               issue_valid,
    output logic [ISSUE_WIDTH-1:0]               issue_mult,
    output logic [ISSUE_WIDTH-1:0][UNIT_LEN-1:0] issue_unit,
    output logic [NUM_MULT-1:0]                  mult_free
);

    logic [INDEX_LEN-1:0]                  base_r;
    logic [NUM_MULT-1:0]                   unit_load_s;
    logic                                  issue_en_s;
    logic [ISSUE_WIDTH-1:0]                slot_valid_s;
    logic [ISSUE_WIDTH-1:0]                slot_mult_s;
    logic [ISSUE_WIDTH-1:0][INDEX_LEN-1:0] slot_idx_s;
    logic [ISSUE_WIDTH-1:0][UNIT_LEN-1:0]  slot_unit_s;

    assign issue_en_s = !reset && !squash && !stall;

    mult_unit_tracker #(
        .NUM_MULT (NUM_MULT),
        .MULT_LAT (MULT_LAT)
    ) u_tracker (
        .clock     (clock),
        .reset     (reset),
        .clear     (squash),
        .load      (unit_load_s),
        .mult_free (mult_free)
    );

    // Rotated priority scan; multiply requests without a remaining unit are skipped.
    always_comb begin
        logic [NUM_MULT-1:0]  avail;
        logic [INDEX_LEN-1:0] p;
        int                   filled;
        int                   unit_sel;
        slot_valid_s = '0;
        slot_mult_s  = '0;
        slot_idx_s   = '0;
        slot_unit_s  = '0;
        avail        = mult_free;
        filled       = 0;
        p            = '0;
        unit_sel     = 0;
        for (int j = 0; j < Q_SIZE; j++) begin
            p        = INDEX_LEN'((int'(base_r) + 2 * Q_SIZE - 1 - j) % Q_SIZE);
            unit_sel = lowest_set(32'(avail));
            if (request[p] && (filled < ISSUE_WIDTH) && (!req_mult[p] || (avail != '0))) begin
                for (int k = 0; k < ISSUE_WIDTH; k++) begin
                    if (k == filled) begin
                        slot_valid_s[k] = 1'b1;
                        slot_idx_s[k]   = p;
                        slot_mult_s[k]  = req_mult[p];
                        slot_unit_s[k]  = req_mult[p] ? UNIT_LEN'(unit_sel) : '0;
                    end else begin
                        slot_valid_s[k] = slot_valid_s[k];
                    end
                end
                for (int u = 0; u < NUM_MULT; u++) begin
                    if (req_mult[p] && (u == unit_sel)) begin
                        avail[u] = 1'b0;
                    end else begin
                        avail[u] = avail[u];
                    end
                end
                filled = filled + 1;
            end else begin
                filled = filled;
            end
        end
    end

    // Gate slots onto the issue ports and derive multiplier loads from live grants.
    always_comb begin
        issue_idx   = '0;
        issue_valid = '0;
        issue_mult  = '0;
        issue_unit  = '0;
        unit_load_s = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (issue_en_s && slot_valid_s[k]) begin
                issue_valid[k] = 1'b1;
                issue_idx[k]   = slot_idx_s[k];
                issue_mult[k]  = slot_mult_s[k];
                issue_unit[k]  = slot_unit_s[k];
                for (int u = 0; u < NUM_MULT; u++) begin
                    if (slot_mult_s[k] && (slot_unit_s[k] == UNIT_LEN'(u))) begin
                        unit_load_s[u] = 1'b1;
                    end else begin
                        unit_load_s[u] = unit_load_s[u];
                    end
                end
            end else begin
                issue_valid[k] = 1'b0;
            end
        end
    end

    // Priority pointer steps down one entry after every accepted issue.
    always_ff @(posedge clock) begin
        if (reset) begin
            base_r <= '0;
        end else if (|issue_valid) begin
            base_r <= (base_r == '0) ? INDEX_LEN'(Q_SIZE - 1) : base_r - INDEX_LEN'(1);
        end else begin
            base_r <= base_r;
        end
    end

endmodule

// File: tb/tb_rs_issue_arbiter.sv
// Directed scoreboard bench for rs_issue_arbiter (Q_SIZE=32, ISSUE_WIDTH=3,
// NUM_MULT=2, MULT_LAT=4); expectations are hand-derived constants.
module tb_rs_issue_arbiter;
    import rs_issue_arbiter_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic [31:0]       request;
    logic [31:0]       req_mult;
    logic              stall;
    logic              squash;
    logic [2:0][4:0]   issue_idx;
    logic [2:0]        issue_valid;
    logic [2:0]        issue_mult;
    logic [2:0][0:0]   issue_unit;
    logic [1:0]        mult_free;

    typedef struct {
        string       tag;
        logic [2:0]  valid;
        logic [14:0] idx;
        logic [2:0]  mult;
        logic [2:0]  unit;
        logic [1:0]  free;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    rs_issue_arbiter #(
        .Q_SIZE      (32),
        .ISSUE_WIDTH (3),
        .NUM_MULT    (2),
        .MULT_LAT    (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .request     (request),
        .req_mult    (req_mult),
        .stall       (stall),
        .squash      (squash),
        .issue_idx   (issue_idx),
        .issue_valid (issue_valid),
        .issue_mult  (issue_mult),
        .issue_unit  (issue_unit),
        .mult_free   (mult_free)
    );

    always #5 clock = ~clock;

    function automatic logic [14:0] ix(input int s0, input int s1, input int s2);
        return {5'(s2), 5'(s1), 5'(s0)};
    endfunction

    task automatic check_head();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            $error("FAIL scoreboard_empty: got 0 entries want 1");
        end else begin
            e = sb.pop_front();
            checks++;
            assert (issue_valid === e.valid) passed++;
            else $error("FAIL %s valid: got %b want %b", e.tag, issue_valid, e.valid);
            checks++;
            assert (issue_idx === e.idx) passed++;
            else $error("FAIL %s idx: got %h want %h", e.tag, issue_idx, e.idx);
            checks++;
            assert (issue_mult === e.mult) passed++;
            else $error("FAIL %s mult: got %b want %b", e.tag, issue_mult, e.mult);
            checks++;
            assert (issue_unit === e.unit) passed++;
            else $error("FAIL %s unit: got %b want %b", e.tag, issue_unit, e.unit);
            checks++;
            assert (mult_free === e.free) passed++;
            else $error("FAIL %s free: got %b want %b", e.tag, mult_free, e.free);
        end
    endtask

    task automatic step(input string tag, input logic [31:0] rq, input logic [31:0] rm,
                        input logic st, input logic sq, input logic rs,
                        input logic [2:0] v, input logic [14:0] idx, input logic [2:0] m,
                        input logic [2:0] u, input logic [1:0] f);
        exp_t e;
        request  = rq;
        req_mult = rm;
        stall    = st;
        squash   = sq;
        reset    = rs;
        e.tag = tag; e.valid = v; e.idx = idx; e.mult = m; e.unit = u; e.free = f;
        sb.push_back(e);
        @(negedge clock);
        check_head();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input string tag);
        step(tag, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 3'b000, 15'h0, 3'b000, 3'b000, 2'b11);
    endtask

    task automatic walk(input int n);
        for (int i = 0; i < n; i++) begin
            step("walk", 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 3'b001, ix(0, 0, 0), 3'b000, 3'b000, 2'b11);
        end
    endtask

    initial begin
        step("reset_cycle", 32'h7, 32'h0, 1'b0, 1'b0, 1'b1, 3'b000, 15'h0, 3'b000, 3'b000, 2'b11);
        step("low3", 32'h7, 32'h0, 1'b0, 1'b0, 1'b0, 3'b111, ix(2, 1, 0), 3'b000, 3'b000, 2'b11);
        step("base31", 32'h8000_0003, 32'h0, 1'b0, 1'b0, 1'b0, 3'b111, ix(1, 0, 31), 3'b000, 3'b000, 2'b11);
        do_reset("reset_a");
        step("bits9_5", 32'h0000_0220, 32'h0, 1'b0, 1'b0, 1'b0, 3'b011, ix(9, 5, 0), 3'b000, 3'b000, 2'b11);
        do_reset("reset_b");
        step("mult_t0", 32'hF0, 32'hF0, 1'b0, 1'b0, 1'b0, 3'b011, ix(7, 6, 0), 3'b011, 3'b010, 2'b11);
        step("mult_t1", 32'h30, 32'h30, 1'b0, 1'b0, 1'b0, 3'b000, 15'h0, 3'b000, 3'b000, 2'b00);
        step("mult_t2", 32'h30, 32'h30, 1'b0, 1'b0, 1'b0, 3'b000, 15'h0, 3'b000, 3'b000, 2'b00);
        step("mult_t3", 32'h30, 32'h30, 1'b0, 1'b0, 1'b0, 3'b000, 15'h0, 3'b000, 3'b000, 2'b00);
        step("mult_t4", 32'h30, 32'h30, 1'b0, 1'b0, 1'b0, 3'b011, ix(5, 4, 0), 3'b011, 3'b010, 2'b11);

        // Walk base down to 2, then a multiply grant leaves base=1 with unit 0 busy.
        do_reset("reset_c");
        walk(30);
        step("mult_b2", 32'h1, 32'h1, 1'b0, 1'b0, 1'b0, 3'b001, ix(0, 0, 0), 3'b001, 3'b000, 2'b11);
        step("stall_a", 32'hFF, 32'h0, 1'b1, 1'b0, 1'b0, 3'b000, 15'h0, 3'b000, 3'b000, 2'b10);
        step("stall_b", 32'hFF, 32'h0, 1'b1, 1'b0, 1'b0, 3'b000, 15'h0, 3'b000, 3'b000, 2'b10);
        step("stall_c", 32'hFF, 32'hFF, 1'b1, 1'b0, 1'b0, 3'b000, 15'h0, 3'b000, 3'b000, 2'b10);
        step("wrap", 32'hC000_0001, 32'h0, 1'b0, 1'b0, 1'b0, 3'b111, ix(0, 31, 30), 3'b000, 3'b000, 2'b11);

        // Build units busy at 3 with base=5, then squash (also overriding stall).
        do_reset("reset_d");
        walk(26);
        step("busy_b6", 32'h3, 32'h3, 1'b0, 1'b0, 1'b0, 3'b011, ix(1, 0, 0), 3'b011, 3'b010, 2'b11);
        step("squash", 32'hFF, 32'h0, 1'b1, 1'b1, 1'b0, 3'b000, 15'h0, 3'b000, 3'b000, 2'b00);
        step("post_squash", 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 3'b111, ix(4, 3, 2), 3'b000, 3'b000, 2'b11);

        // Same state again, then reset with squash asserted together.
        do_reset("reset_e");
        walk(26);
        step("busy_b6_2", 32'h3, 32'h3, 1'b0, 1'b0, 1'b0, 3'b011, ix(1, 0, 0), 3'b011, 3'b010, 2'b11);
        step("reset_sq", 32'hFF, 32'h0, 1'b0, 1'b1, 1'b1, 3'b000, 15'h0, 3'b000, 3'b000, 2'b11);
        step("post_reset", 32'hF0, 32'hE0, 1'b0, 1'b0, 1'b0, 3'b111, ix(7, 6, 4), 3'b011, 3'b010, 2'b11);
        step("no_req", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000, 15'h0, 3'b000, 3'b000, 2'b00);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
